// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a byte FIFO.
//
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high reset
//   sel    - decoder select for this device's address window
//   addr   - byte address; only addr[3:2] is decoded
//   wdata  - store data
//   we     - store strobe; a write happens on a clk edge when sel & we
//   rdata  - combinational read data; 0 when sel is low
//   txd    - serial line output, idle high, registered
//
// Register map (addr[3:2]):
//   0 TXDATA : write pushes wdata[7:0]; reads 0
//   1 STATUS : {count[15:8], overflow[3], busy[2], empty[1], full[0]};
//              writing 1 to bit3 clears overflow
//   2,3      : read 0, writes ignored
module uart_tx_mmio #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sel,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic            we,
  output logic [XLEN-1:0] rdata,
  output logic            txd
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLK_DIV);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_txd;
  logic [BAUD_W-1:0]   r_baud;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;

  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_ovf;

  logic                w_wr_data;
  logic                w_wr_status;
  logic                w_empty;
  logic                w_full;
  logic                w_busy;
  logic                w_baud_end;
  logic                w_pop;
  logic                w_push_ok;
  logic [15:0]         w_status;
  logic                w_unused;

  // Bus decode and FIFO/engine handshake
  assign w_wr_data   = sel & we & (addr[3:2] == 2'd0);
  assign w_wr_status = sel & we & (addr[3:2] == 2'd1);
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_FULL);
  assign w_busy      = (r_state != ST_IDLE);
  assign w_baud_end  = (r_baud == BAUD_LAST);

  // Pop on IDLE->START or STOP->START
  assign w_pop = ~w_empty & ((r_state == ST_IDLE) |
                             ((r_state == ST_STOP) & w_baud_end));

  // A full FIFO still accepts a byte when a pop frees a slot this cycle
  assign w_push_ok = w_wr_data & (~w_full | w_pop);

  assign w_status = {8'(r_count), 4'b0000, r_ovf, w_busy, w_empty, w_full};

  assign w_unused = ^{addr[XLEN-1:4], addr[1:0], wdata[XLEN-1:8]};

  assign txd = r_txd;

  // Combinational read mux so loads complete in the same cycle
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr[3:2])
        2'd1:    rdata = XLEN'(w_status);
        default: rdata = '0;
      endcase
    end
  end

  // FIFO storage; stale entries are harmless since pointers are reset
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= wdata[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_wr_data & ~w_push_ok) begin
        r_ovf <= 1'b1;
      end else if (w_wr_status & wdata[3]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Serial engine; txd is registered alongside the state it belongs to
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_txd     <= 1'b1;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_txd  <= 1'b1;
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_txd   <= 1'b0;
            r_state <= ST_START;
          end
        end

        ST_START: begin
          if (w_baud_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_txd     <= r_shift[0];
            r_state   <= ST_DATA;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end

        ST_DATA: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit_idx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_txd     <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end

        ST_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            // Chain straight into the next frame with no idle gap
            if (w_pop) begin
              r_shift <= r_mem[r_rptr];
              r_txd   <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_txd   <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end

        default: begin
          r_txd   <= 1'b1;
          r_baud  <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed self-checking bench for uart_tx_mmio
// (CLK_DIV=4, FIFO_DEPTH=8). Inputs change and outputs are sampled
// 1 time unit after the rising edge.
module tb_uart_tx_mmio;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned DEPTH   = 8;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic            sel   = 1'b0;
  logic            we    = 1'b0;
  logic [XLEN-1:0] addr  = '0;
  logic [XLEN-1:0] wdata = '0;
  logic [XLEN-1:0] rdata;
  logic            txd;

  int total = 0;
  int bad   = 0;

  uart_tx_mmio #(
    .XLEN      (XLEN),
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sel  (sel),
    .addr (addr),
    .wdata(wdata),
    .we   (we),
    .rdata(rdata),
    .txd  (txd)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    sel   = 1'b1;
    we    = 1'b1;
    addr  = 32'({off, 2'b00});
    wdata = d;
    step();
    sel   = 1'b0;
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic rd(input logic [1:0] off, output logic [31:0] d);
    sel  = 1'b1;
    we   = 1'b0;
    addr = 32'({off, 2'b00});
    #1;
    d    = rdata;
    sel  = 1'b0;
  endtask

  // Checks one 40-cycle frame starting at the current sample point
  task automatic check_frame(input logic [7:0] b, input string name);
    logic [9:0]  fr;
    logic [31:0] s;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10 * CLK_DIV; i++) begin
      total++;
      if (txd !== fr[i / CLK_DIV]) begin
        bad++;
        $display("FAIL %s txd cycle %0d: got %b want %b", name, i, txd, fr[i / CLK_DIV]);
      end
      rd(2'd1, s);
      total++;
      if (s[2] !== 1'b1) begin
        bad++;
        $display("FAIL %s busy cycle %0d: got %b want 1", name, i, s[2]);
      end
      step();
    end
  endtask

  // Finds the next start bit (bounded), samples mid-bit, ends after stop
  task automatic rx_byte(input logic [7:0] exp, input string name);
    int         n;
    logic [7:0] b;
    logic       stop_bit;
    n = 0;
    while (txd !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    total++;
    if (txd !== 1'b0) begin
      bad++;
      $display("FAIL %s start bit: got txd=%b want 0 within 100 cycles", name, txd);
      return;
    end
    repeat (CLK_DIV / 2) step();
    for (int k = 0; k < 8; k++) begin
      repeat (CLK_DIV) step();
      b[k] = txd;
    end
    repeat (CLK_DIV) step();
    stop_bit = txd;
    repeat (CLK_DIV / 2) step();
    total++;
    if (b !== exp) begin
      bad++;
      $display("FAIL %s data: got %h want %h", name, b, exp);
    end
    total++;
    if (stop_bit !== 1'b1) begin
      bad++;
      $display("FAIL %s stop bit: got %b want 1", name, stop_bit);
    end
  endtask

  task automatic test_reset();
    logic [31:0] s;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    total++;
    if (txd !== 1'b1) begin
      bad++;
      $display("FAIL reset_txd: got %b want 1", txd);
    end
    rd(2'd1, s);
    total++;
    if (s !== 32'h0000_0002) begin
      bad++;
      $display("FAIL reset_status: got %h want 00000002", s);
    end
    rd(2'd0, s);
    total++;
    if (s !== 32'h0) begin
      bad++;
      $display("FAIL reset_txdata_read: got %h want 00000000", s);
    end
  endtask

  task automatic test_decode();
    logic [31:0] s;
    logic        line_ok;
    sel   = 1'b0;
    we    = 1'b1;
    addr  = 32'h0;
    wdata = 32'h77;
    step();
    we    = 1'b0;
    wdata = '0;
    rd(2'd1, s);
    total++;
    if (s !== 32'h0000_0002) begin
      bad++;
      $display("FAIL decode_unsel_write_status: got %h want 00000002", s);
    end
    line_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (txd !== 1'b1) line_ok = 1'b0;
      step();
    end
    total++;
    if (line_ok !== 1'b1) begin
      bad++;
      $display("FAIL decode_unsel_write_txd: got low want high");
    end
    rd(2'd2, s);
    total++;
    if (s !== 32'h0) begin
      bad++;
      $display("FAIL decode_read_off2: got %h want 00000000", s);
    end
    rd(2'd3, s);
    total++;
    if (s !== 32'h0) begin
      bad++;
      $display("FAIL decode_read_off3: got %h want 00000000", s);
    end
    sel  = 1'b0;
    addr = 32'h4;
    #1;
    total++;
    if (rdata !== 32'h0) begin
      bad++;
      $display("FAIL decode_read_unsel: got %h want 00000000", rdata);
    end
  endtask

  task automatic test_single_byte();
    logic [31:0] s;
    wr(2'd0, 32'h55);
    total++;
    if (txd !== 1'b1) begin
      bad++;
      $display("FAIL single_txd_after_write: got %b want 1", txd);
    end
    rd(2'd1, s);
    total++;
    if (s !== 32'h0000_0100) begin
      bad++;
      $display("FAIL single_status_after_write: got %h want 00000100", s);
    end
    step();
    check_frame(8'h55, "single");
    total++;
    if (txd !== 1'b1) begin
      bad++;
      $display("FAIL single_txd_idle: got %b want 1", txd);
    end
    rd(2'd1, s);
    total++;
    if (s !== 32'h0000_0002) begin
      bad++;
      $display("FAIL single_status_idle: got %h want 00000002", s);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s;
    wr(2'd0, 32'h00);
    wr(2'd0, 32'hFF);
    rd(2'd1, s);
    total++;
    if (s !== 32'h0000_0104) begin
      bad++;
      $display("FAIL b2b_status: got %h want 00000104", s);
    end
    check_frame(8'h00, "b2b_first");
    check_frame(8'hFF, "b2b_second");
    rd(2'd1, s);
    total++;
    if (s !== 32'h0000_0002 || txd !== 1'b1) begin
      bad++;
      $display("FAIL b2b_idle: got status %h txd %b want 00000002 1", s, txd);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] s;
    logic        line_ok;
    wr(2'd0, 32'hFF);
    for (int i = 1; i <= 8; i++) wr(2'd0, 32'(i));
    rd(2'd1, s);
    total++;
    if (s !== 32'h0000_0805) begin
      bad++;
      $display("FAIL ovf_full_status: got %h want 00000805", s);
    end
    wr(2'd0, 32'hAA);
    rd(2'd1, s);
    total++;
    if (s !== 32'h0000_080D) begin
      bad++;
      $display("FAIL ovf_set_status: got %h want 0000080d", s);
    end
    wr(2'd1, 32'h8);
    rd(2'd1, s);
    total++;
    if (s !== 32'h0000_0805) begin
      bad++;
      $display("FAIL ovf_clear_status: got %h want 00000805", s);
    end
    for (int i = 1; i <= 8; i++) rx_byte(8'(i), "ovf_rx");
    rd(2'd1, s);
    total++;
    if (s !== 32'h0000_0002) begin
      bad++;
      $display("FAIL ovf_drain_status: got %h want 00000002", s);
    end
    line_ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (txd !== 1'b1) line_ok = 1'b0;
      step();
    end
    total++;
    if (line_ok !== 1'b1) begin
      bad++;
      $display("FAIL ovf_dropped_byte_sent: got line activity want idle");
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] s;
    wr(2'd0, 32'h3C);
    for (int i = 1; i <= 8; i++) wr(2'd0, 32'(8'h10 + 8'(i)));
    repeat (32) step();
    rd(2'd1, s);
    total++;
    if (s !== 32'h0000_0805) begin
      bad++;
      $display("FAIL fullpop_before: got %h want 00000805", s);
    end
    wr(2'd0, 32'hC3);
    rd(2'd1, s);
    total++;
    if (s !== 32'h0000_0805) begin
      bad++;
      $display("FAIL fullpop_after: got %h want 00000805", s);
    end
    for (int i = 1; i <= 8; i++) rx_byte(8'h10 + 8'(i), "fullpop_rx");
    rx_byte(8'hC3, "fullpop_rx_last");
    rd(2'd1, s);
    total++;
    if (s !== 32'h0000_0002) begin
      bad++;
      $display("FAIL fullpop_drain_status: got %h want 00000002", s);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s;
    logic        line_ok;
    wr(2'd0, 32'hA5);
    wr(2'd0, 32'h01);
    wr(2'd0, 32'h02);
    wr(2'd0, 32'h03);
    repeat (14) step();
    rd(2'd1, s);
    total++;
    if (s !== 32'h0000_0304) begin
      bad++;
      $display("FAIL rstmid_before: got %h want 00000304", s);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (txd !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_txd: got %b want 1", txd);
    end
    rd(2'd1, s);
    total++;
    if (s !== 32'h0000_0002) begin
      bad++;
      $display("FAIL rstmid_status: got %h want 00000002", s);
    end
    line_ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (txd !== 1'b1) line_ok = 1'b0;
      step();
    end
    total++;
    if (line_ok !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_no_frames: got line activity want idle");
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
